// File: rtl/spram_dma_pkg.sv
// spram_dma_pkg: shared types and constants for the SPRAM word-copy engine.
//   state_e   : engine FSM states
//   MEM_BYTES : SPRAM size in bytes, upper bound for the range check
//   WE_FULL   : full-word byte-enable pattern
package spram_dma_pkg;

  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned LEN_W_DEF  = 16;
  localparam int unsigned MEM_BYTES  = 131072;
  localparam logic [3:0]  WE_FULL    = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/spram_dma_if.sv
// spram_dma_if: initiator side of the shared SPRAM port plus the arbiter req/gnt pair.
//   master : engine drives mem_req/mem_sel/mem_we/mem_addr/mem_wdat, receives mem_gnt/mem_rdat
//   slave  : arbiter/SPRAM side, the mirror image
interface spram_dma_if #(
  parameter int unsigned ADDR_W = spram_dma_pkg::ADDR_W_DEF
);
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_sel;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdat;
  logic [31:0]       mem_rdat;

  modport master (
    output mem_req, mem_sel, mem_we, mem_addr, mem_wdat,
    input  mem_gnt, mem_rdat
  );

  modport slave (
    input  mem_req, mem_sel, mem_we, mem_addr, mem_wdat,
    output mem_gnt, mem_rdat
  );
endinterface

// File: rtl/spram_dma.sv
// spram_dma: word-copy engine sharing the SPRAM port through a req/gnt arbiter.
// Copies len 32-bit words from byte address src to dst, ascending, 3 cycles/word
// under continuous grant. Misaligned or out-of-range requests finish with err set.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, src, dst, len   transfer request (sampled in IDLE only)
//   abort                  stop after the current word's write
//   busy, done, err        status (done is a one-cycle pulse, err is sticky)
//   mem (spram_dma_if)     arbiter/SPRAM port; sel/we/addr/wdat follow gnt in the same cycle
// Optional: define SPRAM_DMA_FILL_EN to add fill/pattern ports; fill=1 writes pattern
// to every destination word at 1 cycle/word without reading.
module spram_dma
  import spram_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
`ifdef SPRAM_DMA_FILL_EN
  input  logic              fill,
  input  logic [31:0]       pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  spram_dma_if.master       mem
);

  localparam int unsigned    CHK_W   = ADDR_W + 3;
  localparam logic [CHK_W-1:0] MEM_LIM = CHK_W'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [31:0]       data_q;
  logic              abort_q, busy_q, done_q, err_q, req_q;

  logic              sel_d;
  logic [3:0]        we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdat_d;
  logic              capture, advance;
  logic              abort_seen, cfg_bad;
  logic [CHK_W-1:0]  src_end, dst_end;
  logic              fill_mode;
  logic [31:0]       pat_word;
  logic              accept;

  assign accept = (state_q == IDLE) && start;

  // Fill configuration exists only in the fill build; otherwise every transfer copies.
`ifdef SPRAM_DMA_FILL_EN
  logic        fill_q;
  logic [31:0] pat_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q <= 1'b0;
      pat_q  <= 32'h0;
    end else if (accept) begin
      fill_q <= fill;
      pat_q  <= pattern;
    end
  end

  assign fill_mode = fill_q;
  assign pat_word  = pat_q;
`else
  assign fill_mode = 1'b0;
  assign pat_word  = 32'h0;
`endif

  // End addresses are formed 3 bits wider than the port so they cannot wrap.
  assign src_end    = CHK_W'(src_q) + (CHK_W'(rem_q) << 2);
  assign dst_end    = CHK_W'(dst_q) + (CHK_W'(rem_q) << 2);
  assign cfg_bad    = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00) ||
                      (!fill_mode && (src_end > MEM_LIM)) || (dst_end > MEM_LIM);
  assign abort_seen = abort_q || abort;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and same-cycle port drive; the port is quiet unless granted, addr holds.
  always_comb begin
    state_d = state_q;
    sel_d   = 1'b0;
    we_d    = 4'h0;
    addr_d  = addr_q;
    wdat_d  = 32'h0;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CHECK;
      end
      CHECK: begin
        if (cfg_bad || (rem_q == '0) || abort_seen) state_d = FIN;
        else if (fill_mode)                          state_d = WRITE;
        else                                         state_d = READ;
      end
      READ: begin
        if (mem.mem_gnt) begin
          sel_d   = 1'b1;
          addr_d  = src_q;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // Bank mux follows addr combinationally, so the source address stays put here.
        if (mem.mem_gnt) begin
          addr_d  = src_q;
          capture = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (mem.mem_gnt) begin
          sel_d   = 1'b1;
          we_d    = WE_FULL;
          addr_d  = dst_q;
          wdat_d  = fill_mode ? pat_word : data_q;
          advance = 1'b1;
          if ((rem_q == LEN_W'(1)) || abort_seen) state_d = FIN;
          else if (fill_mode)                     state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transfer datapath and registered status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      req_q  <= (state_d == READ) || (state_d == CAPTURE) || (state_d == WRITE);
      done_q <= (state_q == FIN);
      if (accept) begin
        src_q   <= src;
        dst_q   <= dst;
        rem_q   <= len;
        busy_q  <= 1'b1;
        err_q   <= 1'b0;
        abort_q <= 1'b0;
      end
      if (busy_q && abort)                  abort_q <= 1'b1;
      if ((state_q == CHECK) && cfg_bad)    err_q   <= 1'b1;
      if (capture)                          data_q  <= mem.mem_rdat;
      if (advance) begin
        src_q <= src_q + ADDR_W'(4);
        dst_q <= dst_q + ADDR_W'(4);
        rem_q <= rem_q - LEN_W'(1);
      end
      if (state_q == FIN)                   busy_q  <= 1'b0;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_sel  = sel_d;
  assign mem.mem_we   = we_d;
  assign mem.mem_addr = addr_d;
  assign mem.mem_wdat = wdat_d;

endmodule

// File: tb/tb_spram_dma.sv
// tb_spram_dma: directed bench for spram_dma with a two-bank SPRAM model and a CPU
// side that owns the port whenever gnt=0. Expected DMA writes and done/err results
// are queued at stimulus time and checked by a monitor on the falling edge.
module tb_spram_dma;
  import spram_dma_pkg::*;

  typedef struct packed {
    logic [16:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, abort;
  logic [16:0] src, dst;
  logic [15:0] len;
  logic        busy, done, err;
  logic        gnt, cpu_sel;
  logic [3:0]  cpu_we;
  logic [16:0] cpu_addr;
  logic [31:0] cpu_wdat;
`ifdef SPRAM_DMA_FILL_EN
  logic        fill;
  logic [31:0] pattern;
`endif

  spram_dma_if #(.ADDR_W(17)) mem_if ();

  spram_dma dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .abort  (abort),
`ifdef SPRAM_DMA_FILL_EN
    .fill   (fill),
    .pattern(pattern),
`endif
    .busy   (busy),
    .done   (done),
    .err    (err),
    .mem    (mem_if)
  );

  always #5 clk = ~clk;

  // SPRAM model: two 64 KB banks, each with its own output register, muxed by addr[16].
  logic [31:0] mem_arr [0:32767];
  logic [31:0] bank_q  [2];
  logic        p_sel;
  logic [3:0]  p_we;
  logic [16:0] p_addr;
  logic [31:0] p_wdat, p_next;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign p_sel  = gnt ? mem_if.mem_sel  : cpu_sel;
  assign p_we   = gnt ? mem_if.mem_we   : cpu_we;
  assign p_addr = gnt ? mem_if.mem_addr : cpu_addr;
  assign p_wdat = gnt ? mem_if.mem_wdat : cpu_wdat;
  assign p_next = merge(mem_arr[p_addr[16:2]], p_wdat, p_we);
  assign mem_if.mem_gnt  = gnt;
  assign mem_if.mem_rdat = bank_q[p_addr[16]];

  always @(posedge clk) begin
    if (p_sel) begin
      mem_arr[p_addr[16:2]] <= p_next;
      bank_q[p_addr[16]]    <= p_next;
    end
  end

  int  n_checks = 0, n_fail = 0;
  int  sel_cnt = 0, rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, req_cnt = 0, done_cnt = 0, quiet_viol = 0;
  int  b_sel, b_rd, b_wr, b_busy, b_req, b_done;
  wr_t exp_wr[$];
  logic exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes/done results as the DUT produces them.
  task automatic monitor();
    wr_t e;
    logic ed;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (mem_if.mem_sel) sel_cnt++;
        if (mem_if.mem_req) req_cnt++;
        if (busy) busy_cnt++;
        if (!gnt && (mem_if.mem_sel || mem_if.mem_we != 4'h0 || mem_if.mem_wdat != 32'h0))
          quiet_viol++;
        if (gnt && mem_if.mem_sel && mem_if.mem_we == 4'h0) rd_cnt++;
        if (gnt && mem_if.mem_sel && mem_if.mem_we != 4'h0) begin
          wr_cnt++;
          check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("write_addr", 64'(mem_if.mem_addr), 64'(e.addr));
            check("write_data", 64'(mem_if.mem_wdat), 64'(e.data));
            check("write_we",   64'(mem_if.mem_we),   64'(WE_FULL));
          end
        end
        if (done) begin
          done_cnt++;
          check("done_expected", 64'(exp_done.size() != 0), 64'd1);
          if (exp_done.size() != 0) begin
            ed = exp_done.pop_front();
            check("done_err", 64'(err), 64'(ed));
          end
        end
      end
    end
  endtask

  task automatic snap();
    b_sel = sel_cnt; b_rd = rd_cnt; b_wr = wr_cnt;
    b_busy = busy_cnt; b_req = req_cnt; b_done = done_cnt;
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic cpu_write(input logic [16:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    gnt = 1'b0; cpu_sel = 1'b1; cpu_we = 4'hF; cpu_addr = a; cpu_wdat = d;
    @(posedge clk); #1;
    cpu_sel = 1'b0; cpu_we = 4'h0;
  endtask

  task automatic pulse_start(input logic [16:0] s, input logic [16:0] d, input logic [15:0] l);
    @(posedge clk); #1;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_access(input string name, input logic is_wr, input logic [16:0] a);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      if (gnt && mem_if.mem_sel && ((mem_if.mem_we != 4'h0) == is_wr) && mem_if.mem_addr == a)
        seen = 1'b1;
    end
    check({name, "_access_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, busy=%0b", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
    gnt = 1'b0; cpu_sel = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdat = 32'h0;
`ifdef SPRAM_DMA_FILL_EN
    fill = 1'b0; pattern = 32'h0;
`endif
    fork monitor(); join_none

    // Reset values
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err",  64'(err),  64'd0);
    check("rst_req",  64'(mem_if.mem_req),  64'd0);
    check("rst_sel",  64'(mem_if.mem_sel),  64'd0);
    check("rst_we",   64'(mem_if.mem_we),   64'd0);
    check("rst_addr", 64'(mem_if.mem_addr), 64'd0);
    check("rst_wdat", 64'(mem_if.mem_wdat), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic 4-word copy, continuous grant
    for (int i = 0; i < 4; i++) cpu_write(17'h00100 + 17'(4*i), 32'h11111111 * (i + 1));
    for (int i = 0; i < 4; i++) push_wr(17'h10000 + 17'(4*i), 32'h11111111 * (i + 1));
    exp_done.push_back(1'b0);
    gnt = 1'b1;
    snap();
    pulse_start(17'h00100, 17'h10000, 16'd4);
    wait_done("basic");
    check("basic_busy_cycles", 64'(busy_cnt - b_busy), 64'd14);
    check("basic_req_cycles",  64'(req_cnt - b_req),   64'd12);
    check("basic_reads",       64'(rd_cnt - b_rd),     64'd4);
    check("basic_writes",      64'(wr_cnt - b_wr),     64'd4);
    check("basic_done_pulses", 64'(done_cnt - b_done), 64'd1);
    check("basic_mem_last",    64'(mem_arr[17'h1000C >> 2]), 64'h44444444);

    // Source straddles the bank boundary
    for (int i = 0; i < 4; i++) cpu_write(17'h0FFF8 + 17'(4*i), 32'hB0000001 + 32'(i));
    for (int i = 0; i < 4; i++) push_wr(17'h1FF00 + 17'(4*i), 32'hB0000001 + 32'(i));
    exp_done.push_back(1'b0);
    gnt = 1'b1;
    snap();
    pulse_start(17'h0FFF8, 17'h1FF00, 16'd4);
    wait_done("bank");
    check("bank_writes", 64'(wr_cnt - b_wr), 64'd4);

    // Grant dropped for 2 cycles during CAPTURE of word 1 while the CPU writes elsewhere
    for (int i = 0; i < 3; i++) cpu_write(17'h00200 + 17'(4*i), 32'hC0000001 + 32'(i));
    for (int i = 0; i < 3; i++) push_wr(17'h00300 + 17'(4*i), 32'hC0000001 + 32'(i));
    exp_done.push_back(1'b0);
    gnt = 1'b1;
    snap();
    pulse_start(17'h00200, 17'h00300, 16'd3);
    wait_access("gnt_drop", 1'b0, 17'h00204);
    @(posedge clk); #1;
    gnt = 1'b0; cpu_sel = 1'b1; cpu_we = 4'hF; cpu_addr = 17'h00400; cpu_wdat = 32'hDEADBEEF;
    @(posedge clk); #1;
    cpu_sel = 1'b0; cpu_we = 4'h0;
    @(posedge clk); #1;
    gnt = 1'b1;
    wait_done("gnt_drop");
    check("gnt_drop_reads",  64'(rd_cnt - b_rd), 64'd4);
    check("gnt_drop_writes", 64'(wr_cnt - b_wr), 64'd3);
    check("gnt_drop_word1",  64'(mem_arr[17'h00304 >> 2]), 64'hC0000002);
    check("gnt_drop_cpu",    64'(mem_arr[17'h00400 >> 2]), 64'hDEADBEEF);

    // Misaligned source
    exp_done.push_back(1'b1);
    snap();
    pulse_start(17'h00102, 17'h00300, 16'd2);
    wait_done("misalign");
    check("misalign_sel_cycles", 64'(sel_cnt - b_sel), 64'd0);
    check("misalign_err_sticky", 64'(err), 64'd1);
    check("misalign_busy_cycles", 64'(busy_cnt - b_busy), 64'd2);

    // Destination runs past the end of memory
    exp_done.push_back(1'b1);
    snap();
    pulse_start(17'h00100, 17'h1FFFC, 16'd2);
    wait_done("dst_range");
    check("dst_range_sel_cycles", 64'(sel_cnt - b_sel), 64'd0);

    // Destination ends exactly at the top of memory: allowed
    push_wr(17'h1FFF8, 32'h11111111);
    push_wr(17'h1FFFC, 32'h22222222);
    exp_done.push_back(1'b0);
    snap();
    pulse_start(17'h00100, 17'h1FFF8, 16'd2);
    wait_done("top_edge");
    check("top_edge_writes", 64'(wr_cnt - b_wr), 64'd2);

    // Zero length: done, err cleared, no access
    exp_done.push_back(1'b1);
    snap();
    pulse_start(17'h00102, 17'h00300, 16'd2);
    wait_done("err_again");
    exp_done.push_back(1'b0);
    snap();
    pulse_start(17'h00100, 17'h00300, 16'd0);
    wait_done("len0");
    check("len0_sel_cycles", 64'(sel_cnt - b_sel), 64'd0);
    check("len0_err", 64'(err), 64'd0);

    // Abort during READ of word 2 of an 8-word copy
    for (int i = 0; i < 8; i++) cpu_write(17'h00500 + 17'(4*i), 32'h50000000 + 32'(i));
    for (int i = 0; i < 3; i++) push_wr(17'h00600 + 17'(4*i), 32'h50000000 + 32'(i));
    exp_done.push_back(1'b0);
    gnt = 1'b1;
    snap();
    pulse_start(17'h00500, 17'h00600, 16'd8);
    wait_access("abort", 1'b1, 17'h00604);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done("abort");
    check("abort_writes", 64'(wr_cnt - b_wr), 64'd3);
    check("abort_busy_cycles", 64'(busy_cnt - b_busy), 64'd11);
    check("abort_busy_low", 64'(busy), 64'd0);

`ifdef SPRAM_DMA_FILL_EN
    // Pattern fill, no reads
    for (int i = 0; i < 16; i++) push_wr(17'h08000 + 17'(4*i), 32'hA5A5A5A5);
    exp_done.push_back(1'b0);
    gnt = 1'b1;
    fill = 1'b1; pattern = 32'hA5A5A5A5;
    snap();
    pulse_start(17'h00000, 17'h08000, 16'd16);
    fill = 1'b0; pattern = 32'h0;
    wait_done("fill");
    check("fill_busy_cycles", 64'(busy_cnt - b_busy), 64'd18);
    check("fill_reads",       64'(rd_cnt - b_rd),     64'd0);
    check("fill_writes",      64'(wr_cnt - b_wr),     64'd16);
`endif

    // Reset asserted mid-transfer
    push_wr(17'h00700, 32'h11111111);
    gnt = 1'b1;
    pulse_start(17'h00100, 17'h00700, 16'd4);
    wait_access("midrst", 1'b1, 17'h00700);
    @(posedge clk); #1 resetn = 1'b0;
    snap();
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_sel",  64'(mem_if.mem_sel), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_sel_cycles", 64'(sel_cnt - b_sel), 64'd0);
    check("midrst_req_cycles", 64'(req_cnt - b_req), 64'd0);
    check("midrst_done",       64'(done_cnt - b_done), 64'd0);

    check("quiet_without_gnt", 64'(quiet_viol), 64'd0);
    check("exp_writes_left",   64'(exp_wr.size()), 64'd0);
    check("exp_done_left",     64'(exp_done.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spram_dma.md
Name: spram_dma

Overview:
- Initiator-side word-copy engine for the 128 KB single-port SPRAM slave port (sel / we[3:0] / addr[16:0] / wdat / rdat).
- Copies a block of 32-bit words from a source byte address to a destination byte address within the same SPRAM.
- Sits beside the CPU and uses a req/gnt handshake to share the SPRAM port through the SoC arbiter.

Parameters:
- ADDR_W, 17, byte address width of the SPRAM port.
- LEN_W, 16, width of the word-count input; 32768 words maximum.
- MEM_BYTES, 131072, memory size in bytes, used for range checking.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- src  in  ADDR_W  source byte address
- dst  in  ADDR_W  destination byte address
- len  in  LEN_W  number of words to copy
- abort  in  1  stops the transfer after the current word's write
- busy  out  1  high from the start acceptance cycle until completion
- done  out  1  one-cycle pulse when the transfer finishes or aborts
- err  out  1  sticky; cleared by the next accepted start
- mem_req  out  1  port request to the arbiter
- mem_gnt  in  1  arbiter grant, valid in the same cycle
- mem_sel  out  1  SPRAM chip select
- mem_we  out  4  byte write enables
- mem_addr  out  ADDR_W  byte address
- mem_wdat  out  32  write data
- mem_rdat  in  32  read data, registered by the SPRAM, valid the cycle after a read

Behaviour:
- Reset values: busy=0, done=0, err=0, mem_req=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdat=0; state=IDLE.
- Reset asserted mid-transfer abandons the transfer with no further memory cycles.
- States: IDLE, CHECK, READ, CAPTURE, WRITE, FIN.
- IDLE, start=1: latch src, dst and len; busy=1; clear err; go to CHECK.
- CHECK (1 cycle) sets err=1 and goes to FIN if any of these hold:
  - src[1:0]!=0 or dst[1:0]!=0;
  - src+4*len > MEM_BYTES or dst+4*len > MEM_BYTES, computed at ADDR_W+3 bits with no wrap.
- CHECK with len=0 goes to FIN with no memory access and err=0. Otherwise go to READ.
- mem_req=1 in READ, CAPTURE and WRITE.
- mem_sel, mem_we, mem_addr and mem_wdat are driven only when mem_gnt=1. Otherwise they are 0, except that mem_addr holds its value.
- READ: when gnt=1, drive sel=1, we=0, addr=cur_src and go to CAPTURE. When gnt=0, stay in READ.
- CAPTURE: drive sel=0 and keep addr=cur_src. The SPRAM bank-select mux is combinational on addr, so addr must not change in this cycle.
  - gnt=1: latch mem_rdat into the data register and go to WRITE.
  - gnt=0: the CPU may have clobbered rdat, so go back to READ and re-issue the read.
- WRITE: when gnt=1, drive sel=1, we=4'hF, addr=cur_dst, wdat=data register. Then:
  - cur_src+=4, cur_dst+=4, remaining-=1;
  - go to FIN if remaining reaches 0 or abort was seen; otherwise go to READ.
  - When gnt=0, stay in WRITE.
- abort is sticky-latched at any point while busy and acted on at the next WRITE completion. Abort in CHECK goes to FIN immediately.
- FIN: done=1 for one cycle, busy=0, mem_req=0, return to IDLE.
- Throughput is 3 cycles per word under continuous grant. A length-N copy with continuous grant has busy high for 3N+2 cycles.
- Copy direction is ascending only. Overlap with dst>src and dst<src+4*len replicates source data; this is defined behaviour and not flagged.
- start while busy is ignored.

Optional Feature:
- Macro SPRAM_DMA_FILL_EN adds ports fill (in, 1) and pattern (in, 32), both latched at start.
- With the macro defined and fill=1:
  - READ and CAPTURE are skipped and the src range check is not applied;
  - WRITE writes pattern to each destination word, at 1 cycle per word under grant.
- Without the macro, the ports do not exist and every transfer is a copy.

Decomposition:
- Package spram_dma_pkg holds:
  - state enum (IDLE, CHECK, READ, CAPTURE, WRITE, FIN);
  - MEM_BYTES constant;
  - WE_FULL=4'hF constant.
- No sub-module needed. The range-check comparator may be a function in the package.

Test Plan:
- Preload words 0x11111111..0x44444444 at 0x00100; start src=0x00100 dst=0x10000 len=4, gnt tied 1 -> dst words match; busy high 14 cycles; done pulses once; err=0.
- Bank crossing: src=0x0FFF8 len=4 dst=0x1FF00 -> source words from both bank0 and bank1 copied correctly. This verifies addr is held through CAPTURE.
- Drop gnt for 2 cycles during CAPTURE of word 1, with the CPU writing 0xDEADBEEF to an unrelated address -> READ re-issued; destination data correct; no extra write.
- src=0x00102 -> err=1, done pulse, zero mem_sel cycles. dst=0x1FFFC len=2 -> err=1. len=0 -> done with err=0 and no access.
- len=8 with abort pulsed during word 2 READ -> exactly 3 words written, then done; busy deasserts.
- SPRAM_DMA_FILL_EN: fill=1 pattern=0xA5A5A5A5 dst=0x08000 len=16 -> 16 words filled; busy 18 cycles; no reads issued.
